// File: rtl/lu_row_store.sv
// Row-organised complex matrix store answering the LU engine's row read/write-back port.
// Optional macro LU_ROW_STORE_BYPASS_EN: same-cycle same-row read returns the incoming write data.
module lu_row_store #(
   parameter int SIZE = 16,
   localparam int AW  = $clog2(SIZE),
   localparam int W   = SIZE * 128
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          flush_i,
   input  logic [W-1:0]  ld_row_i,
   input  logic          ld_valid_i,
   output logic          ld_ready_o,
   output logic          start_o,
   input  logic          lu_busy_i,
   input  logic [AW-1:0] rd_addr_i,
   input  logic          rd_addr_valid_i,
   output logic [W-1:0]  rd_row_o,
   output logic [AW-1:0] rd_row_addr_o,
   output logic          rd_row_valid_o,
   input  logic [W-1:0]  wr_row_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic          wr_valid_i,
   output logic          wr_ready_o,
   output logic [W-1:0]  dump_row_o,
   output logic [AW-1:0] dump_addr_o,
   output logic          dump_valid_o,
   input  logic          dump_ready_i,
   output logic          done_o,
   output logic          busy_o
);

   typedef enum logic [1:0] {LOAD, START, SERVE, DUMP} state_t;

   localparam logic [AW-1:0] LAST = AW'(SIZE - 1);

   state_t        state;
   state_t        next_state;
   logic [AW-1:0] ptr;
   logic          seen_busy;
   logic [W-1:0]  mem [SIZE];
   logic [W-1:0]  rd_data;
   logic          ld_fire;
   logic          wr_fire;
   logic          rd_fire;
   logic          dump_fire;

   assign ld_fire   = ld_valid_i && ld_ready_o && !flush_i;
   assign wr_fire   = wr_valid_i && wr_ready_o && !flush_i;
   assign rd_fire   = rd_addr_valid_i && (state == SERVE) && !flush_i;
   assign dump_fire = dump_valid_o && dump_ready_i && !flush_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= LOAD;
      else         state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (flush_i) begin
         next_state = LOAD;
      end else begin
         case (state)
            LOAD:    if (ld_fire && ptr == LAST) next_state = START;
            START:   next_state = SERVE;
            // the engine must have been seen busy before idle means finished
            SERVE:   if (seen_busy && !lu_busy_i) next_state = DUMP;
            DUMP:    if (dump_fire && ptr == LAST) next_state = LOAD;
            default: next_state = LOAD;
         endcase
      end
   end

   always_comb begin
      ld_ready_o   = (state == LOAD);
      wr_ready_o   = (state == SERVE);
      dump_valid_o = (state == DUMP);
      busy_o       = (state != LOAD);
      dump_row_o   = mem[ptr];
      dump_addr_o  = ptr;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr            <= '0;
         seen_busy      <= 1'b0;
         start_o        <= 1'b0;
         done_o         <= 1'b0;
         rd_row_valid_o <= 1'b0;
         rd_row_o       <= '0;
         rd_row_addr_o  <= '0;
      end else if (flush_i) begin
         ptr            <= '0;
         seen_busy      <= 1'b0;
         start_o        <= 1'b0;
         done_o         <= 1'b0;
         rd_row_valid_o <= 1'b0;
         rd_row_o       <= '0;
         rd_row_addr_o  <= '0;
      end else begin
         if (ld_fire || dump_fire) ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
         if (state == START)                 seen_busy <= 1'b0;
         else if (state == SERVE && lu_busy_i) seen_busy <= 1'b1;
         start_o        <= ld_fire && (ptr == LAST);
         done_o         <= dump_fire && (ptr == LAST);
         rd_row_valid_o <= rd_fire;
         if (rd_fire) begin
            rd_row_o      <= rd_data;
            rd_row_addr_o <= rd_addr_i;
         end
      end
   end

`ifdef LU_ROW_STORE_BYPASS_EN
   assign rd_data = (wr_fire && wr_addr_i == rd_addr_i) ? wr_row_i : mem[rd_addr_i];
`else
   assign rd_data = mem[rd_addr_i];
`endif

   // storage deliberately has no reset so a flush keeps the matrix contents
   always_ff @(posedge clk_i) begin
      if (ld_fire) mem[ptr]       <= ld_row_i;
      if (wr_fire) mem[wr_addr_i] <= wr_row_i;
   end

endmodule
